// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer-width helper and show-ahead mode constants
package fifo_pkg;
  localparam bit SA_STD = 1'b0;
  localparam bit SA_FWFT = 1'b1;
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/fifo_sync_param_ram.sv
// fifo_sync_param_ram: simple dual-port RAM with registered read and no array reset
module fifo_sync_param_ram #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: synchronous FIFO with show-ahead option, programmable flags and event pulses
module fifo_sync_param import fifo_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter bit SHOW_AHEAD = SA_FWFT,
  parameter logic [DATA_WIDTH-1:0] DOUT_INITVAL = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          we,
  input  logic [DATA_WIDTH-1:0]         di,
  input  logic                          re,
  input  logic [ptr_w(ADDR_WIDTH)-1:0]  afull_th,
  input  logic [ptr_w(ADDR_WIDTH)-1:0]  aempty_th,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          valid,
  output logic                          empty_flag,
  output logic                          full_flag,
  output logic                          aempty,
  output logic                          afull,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          wr_success,
  output logic [ptr_w(ADDR_WIDTH)-1:0]  usedw,
  output logic [ptr_w(ADDR_WIDTH)-1:0]  peak_usedw
);
  localparam int PW = ptr_w(ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH = PW'(2**ADDR_WIDTH);
  logic [PW-1:0] r_wptr, r_rptr, r_usedw, r_peak, w_usedw_nxt, w_raddr, w_ram_a;
  logic r_valid, r_init, r_ovf, r_udf, r_wok;
  logic w_wr, w_rd, w_valid_nxt;
  logic [DATA_WIDTH-1:0] w_q;
  assign w_wr = we & ~full_flag & ~flush;
  assign w_rd = re & ~empty_flag & ~flush;
  assign w_raddr = r_rptr + PW'(w_rd);
  assign w_usedw_nxt = r_usedw + PW'(w_wr) - PW'(w_rd);
  // show-ahead prefetches the next word; it is only readable once written before this edge
  assign w_ram_a = (SHOW_AHEAD == SA_FWFT) ? w_raddr : r_rptr;
  assign w_valid_nxt = (SHOW_AHEAD == SA_FWFT) ? (w_raddr != r_wptr) : w_rd;
  fifo_sync_param_ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
    .i_wdata (di),
    .i_re    ((SHOW_AHEAD == SA_FWFT) | w_rd),
    .i_raddr (w_ram_a[ADDR_WIDTH-1:0]),
    .o_rdata (w_q)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_usedw <= '0;
      r_peak  <= '0;
      r_valid <= 1'b0;
      r_init  <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      r_wok   <= 1'b0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_usedw <= '0;
      r_peak  <= '0;
      r_valid <= 1'b0;
      r_init  <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      r_wok   <= 1'b0;
    end else begin
      r_wptr  <= r_wptr + PW'(w_wr);
      r_rptr  <= w_raddr;
      r_usedw <= w_usedw_nxt;
      r_peak  <= (w_usedw_nxt > r_peak) ? w_usedw_nxt : r_peak;
      r_valid <= w_valid_nxt;
      r_init  <= r_init & ~w_valid_nxt;
      r_ovf   <= we & full_flag;
      r_udf   <= re & empty_flag;
      r_wok   <= w_wr;
    end
  end
  // the RAM output register is never reset, so mask it until a real word lands
  assign dout       = r_init ? DOUT_INITVAL : w_q;
  assign valid      = r_valid;
  assign usedw      = r_usedw;
  assign peak_usedw = r_peak;
  assign empty_flag = (r_usedw == '0);
  assign full_flag  = (r_usedw == DEPTH);
  assign afull      = rst_n & (r_usedw >= afull_th);
  assign aempty     = (r_usedw <= aempty_th);
  assign overflow   = r_ovf;
  assign underflow  = r_udf;
  assign wr_success = r_wok;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed scoreboard bench for the show-ahead FIFO
module tb_fifo_sync_param;
  localparam int DEPTH = 1024;
  logic clk, rst_n, flush, we, re;
  logic [7:0] di, dout;
  logic [10:0] afull_th, aempty_th, usedw, peak_usedw;
  logic valid, empty_flag, full_flag, aempty, afull, overflow, underflow, wr_success;
  int n_cmp = 0, n_fail = 0, cnt = 0;
  logic [7:0] exp_q[$];
  fifo_sync_param dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .we(we), .di(di), .re(re),
    .afull_th(afull_th), .aempty_th(aempty_th), .dout(dout), .valid(valid),
    .empty_flag(empty_flag), .full_flag(full_flag), .aempty(aempty), .afull(afull),
    .overflow(overflow), .underflow(underflow), .wr_success(wr_success),
    .usedw(usedw), .peak_usedw(peak_usedw)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    logic wa, ra;
    we = w; di = d; re = r;
    wa = w && cnt < DEPTH;
    ra = r && cnt > 0;
    if (ra) begin
      chk("rd_valid", valid, 1);
      chk("rd_data", dout, exp_q.pop_front());
    end
    if (wa) exp_q.push_back(d);
    cnt = cnt + int'(wa) - int'(ra);
    @(posedge clk); #1;
    we = 0; re = 0;
    chk("usedw", usedw, cnt);
  endtask
  task automatic chk_idle_reset(input string tag);
    chk({tag, "_usedw"}, usedw, 0);
    chk({tag, "_peak"}, peak_usedw, 0);
    chk({tag, "_empty"}, empty_flag, 1);
    chk({tag, "_full"}, full_flag, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_wrok"}, wr_success, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_udf"}, underflow, 0);
  endtask
  initial begin
    rst_n = 0; flush = 0; we = 0; re = 0; di = 0;
    afull_th = 11'd1000; aempty_th = 11'd3;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_reset("rst");
    chk("rst_aempty", aempty, 1);
    chk("rst_afull", afull, 0);
    rst_n = 1;
    cyc(0, 0, 0);
    cyc(1, 8'hA5, 0);
    chk("a5_wrok", wr_success, 1);
    chk("a5_valid_early", valid, 0);
    cyc(0, 0, 0);
    chk("a5_valid", valid, 1);
    chk("a5_dout", dout, 8'hA5);
    cyc(0, 0, 1);
    chk("a5_empty", empty_flag, 1);
    chk("a5_valid_after", valid, 0);
    cyc(0, 0, 1);
    chk("udf_pulse", underflow, 1);
    cyc(0, 0, 0);
    chk("udf_clear", underflow, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, i[7:0], 0);
      chk("fill_wrok", wr_success, 1);
      chk("fill_aempty", aempty, cnt <= 3);
      chk("fill_afull", afull, cnt >= 1000);
    end
    chk("full_flag", full_flag, 1);
    chk("full_peak", peak_usedw, 1024);
    cyc(1, 8'hEE, 0);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_wrok", wr_success, 0);
    chk("ovf_full", full_flag, 1);
    chk("ovf_head", dout, 8'h00);
    cyc(0, 0, 0);
    chk("ovf_clear", overflow, 0);
    for (int i = 0; i < 512; i++) cyc(0, 0, 1);
    for (int i = 0; i < 2000; i++) cyc(1, 8'($urandom), 1);
    chk("stream_peak", peak_usedw, 1024);
    for (int i = 0; i < 212; i++) cyc(0, 0, 1);
    chk("pre_flush_usedw", usedw, 300);
    flush = 1; we = 1; re = 1; di = 8'h5A;
    @(posedge clk); #1;
    flush = 0; we = 0; re = 0;
    exp_q.delete(); cnt = 0;
    chk_idle_reset("flush");
    for (int i = 0; i < 20; i++) cyc(1, 8'(i + 7), 0);
    cyc(1, 8'h99, 0);
    #3 rst_n = 0;
    #1;
    chk_idle_reset("async");
    chk("async_aempty", aempty, 1);
    chk("async_afull", afull, 0);
    @(posedge clk); #1;
    rst_n = 1;
    exp_q.delete(); cnt = 0;
    cyc(0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 8'h30 + 8'(i), 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1);
    chk("refill_empty", empty_flag, 1);
    chk("refill_q", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
